// File: rtl/layer_scroll_seq.sv
// Per-frame scroll sequencer: buffers position/velocity commands in shadow registers
// and commits them, advanced by velocity, to the active offsets at the start of vblank.
module layer_scroll_seq #(
    parameter int NLAYERS = 4,
    parameter int HWIDTH  = 12,
    parameter int VWIDTH  = 12,
    parameter int HSIZE   = 640,
    parameter int VSIZE   = 480,
    parameter int LWIDTH  = (NLAYERS > 1) ? $clog2(NLAYERS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [HWIDTH-1:0]         hdata,
    input  logic [VWIDTH-1:0]         vdata,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [LWIDTH-1:0]         cmd_layer,
    input  logic [1:0]                cmd_op,
    input  logic signed [HWIDTH-1:0]  cmd_h,
    input  logic signed [VWIDTH-1:0]  cmd_v,
    output logic                      cmd_err,
    output logic [NLAYERS*HWIDTH-1:0] hoffset,
    output logic [NLAYERS*VWIDTH-1:0] voffset,
    output logic                      frame_tick,
    output logic                      busy,
    output logic                      dbg_state
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_APPLY = 1'b1
    } state_t;

    localparam logic [1:0] OP_SET_POS  = 2'd0;
    localparam logic [1:0] OP_SET_VEL  = 2'd1;
    localparam logic [1:0] OP_ADD_POS  = 2'd2;
    localparam logic [1:0] OP_STOP_ALL = 2'd3;

    localparam logic signed [HWIDTH:0] HMOD = (HWIDTH+1)'(HSIZE);
    localparam logic signed [HWIDTH:0] HMAX = (HWIDTH+1)'(HSIZE - 1);
    localparam logic signed [HWIDTH:0] HMIN = -HMAX;
    localparam logic signed [VWIDTH:0] VMOD = (VWIDTH+1)'(VSIZE);
    localparam logic signed [VWIDTH:0] VMAX = (VWIDTH+1)'(VSIZE - 1);
    localparam logic signed [VWIDTH:0] VMIN = -VMAX;

    state_t              state_q, state_d;
    logic [LWIDTH-1:0]   idx_q, idx_d;
    logic                tick_q, tick_d;
    logic                err_q, err_d;
    logic [HWIDTH-1:0]   sp_h_q  [NLAYERS];
    logic [HWIDTH-1:0]   sp_h_d  [NLAYERS];
    logic [VWIDTH-1:0]   sp_v_q  [NLAYERS];
    logic [VWIDTH-1:0]   sp_v_d  [NLAYERS];
    logic [HWIDTH-1:0]   vel_h_q [NLAYERS];
    logic [HWIDTH-1:0]   vel_h_d [NLAYERS];
    logic [VWIDTH-1:0]   vel_v_q [NLAYERS];
    logic [VWIDTH-1:0]   vel_v_d [NLAYERS];
    logic [HWIDTH-1:0]   act_h_q [NLAYERS];
    logic [HWIDTH-1:0]   act_h_d [NLAYERS];
    logic [VWIDTH-1:0]   act_v_q [NLAYERS];
    logic [VWIDTH-1:0]   act_v_d [NLAYERS];

    logic                    boundary;
    logic                    layer_ok;
    logic                    pos_ok;
    logic                    mag_ok;
    logic signed [HWIDTH:0]  h_ext;
    logic signed [VWIDTH:0]  v_ext;
    logic [HWIDTH-1:0]       new_h;
    logic [VWIDTH-1:0]       new_v;

    // Operands are a wrapped position plus a bounded step, so one correction suffices.
    function automatic logic [HWIDTH-1:0] wrap_h(input logic [HWIDTH-1:0] a,
                                                 input logic [HWIDTH-1:0] b);
        logic signed [HWIDTH:0] x;
        x = $signed({a[HWIDTH-1], a}) + $signed({b[HWIDTH-1], b});
        if (x >= HMOD)
            x = x - HMOD;
        else if (x[HWIDTH])
            x = x + HMOD;
        return x[HWIDTH-1:0];
    endfunction

    function automatic logic [VWIDTH-1:0] wrap_v(input logic [VWIDTH-1:0] a,
                                                 input logic [VWIDTH-1:0] b);
        logic signed [VWIDTH:0] x;
        x = $signed({a[VWIDTH-1], a}) + $signed({b[VWIDTH-1], b});
        if (x >= VMOD)
            x = x - VMOD;
        else if (x[VWIDTH])
            x = x + VMOD;
        return x[VWIDTH-1:0];
    endfunction

    assign boundary = (hdata == '0) && (vdata == VWIDTH'(VSIZE));
    assign h_ext    = {cmd_h[HWIDTH-1], cmd_h};
    assign v_ext    = {cmd_v[VWIDTH-1], cmd_v};
    assign layer_ok = (32'(cmd_layer) < NLAYERS);
    assign pos_ok   = !h_ext[HWIDTH] && (h_ext < HMOD) && !v_ext[VWIDTH] && (v_ext < VMOD);
    assign mag_ok   = (h_ext <= HMAX) && (h_ext >= HMIN) && (v_ext <= VMAX) && (v_ext >= VMIN);
    assign new_h    = wrap_h(sp_h_q[idx_q], vel_h_q[idx_q]);
    assign new_v    = wrap_v(sp_v_q[idx_q], vel_v_q[idx_q]);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tick_d  = 1'b0;
        err_d   = 1'b0;
        sp_h_d  = sp_h_q;
        sp_v_d  = sp_v_q;
        vel_h_d = vel_h_q;
        vel_v_d = vel_v_q;
        act_h_d = act_h_q;
        act_v_d = act_v_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    unique case (cmd_op)
                        OP_SET_POS: begin
                            if (layer_ok && pos_ok) begin
                                sp_h_d[cmd_layer] = cmd_h;
                                sp_v_d[cmd_layer] = cmd_v;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_SET_VEL: begin
                            if (layer_ok && mag_ok) begin
                                vel_h_d[cmd_layer] = cmd_h;
                                vel_v_d[cmd_layer] = cmd_v;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_ADD_POS: begin
                            if (layer_ok && mag_ok) begin
                                sp_h_d[cmd_layer] = wrap_h(sp_h_q[cmd_layer], cmd_h);
                                sp_v_d[cmd_layer] = wrap_v(sp_v_q[cmd_layer], cmd_v);
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_STOP_ALL: begin
                            for (int i = 0; i < NLAYERS; i++) begin
                                vel_h_d[i] = '0;
                                vel_v_d[i] = '0;
                            end
                        end
                    endcase
                end
                // The command above lands in shadow before APPLY reads it.
                if (boundary) begin
                    state_d = S_APPLY;
                    idx_d   = '0;
                    tick_d  = 1'b1;
                end
            end
            S_APPLY: begin
                sp_h_d[idx_q]  = new_h;
                sp_v_d[idx_q]  = new_v;
                act_h_d[idx_q] = new_h;
                act_v_d[idx_q] = new_v;
                if (idx_q == LWIDTH'(NLAYERS - 1)) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            tick_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < NLAYERS; i++) begin
                sp_h_q[i]  <= '0;
                sp_v_q[i]  <= '0;
                vel_h_q[i] <= '0;
                vel_v_q[i] <= '0;
                act_h_q[i] <= '0;
                act_v_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tick_q  <= tick_d;
            err_q   <= err_d;
            sp_h_q  <= sp_h_d;
            sp_v_q  <= sp_v_d;
            vel_h_q <= vel_h_d;
            vel_v_q <= vel_v_d;
            act_h_q <= act_h_d;
            act_v_q <= act_v_d;
        end
    end

    always_comb begin
        hoffset = '0;
        voffset = '0;
        for (int i = 0; i < NLAYERS; i++) begin
            hoffset[i*HWIDTH +: HWIDTH] = act_h_q[i];
            voffset[i*VWIDTH +: VWIDTH] = act_v_q[i];
        end
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign busy       = (state_q == S_APPLY);
    assign frame_tick = tick_q;
    assign cmd_err    = err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_layer_scroll_seq.sv
// Bench for layer_scroll_seq: directed scenarios plus random traffic, all outputs
// compared every cycle against a per-layer arithmetic model.
module tb_layer_scroll_seq;
  localparam int N  = 4;
  localparam int HW = 12;
  localparam int VW = 12;
  localparam int HS = 640;
  localparam int VS = 480;
  localparam int LW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [HW-1:0]        hdata;
  logic [VW-1:0]        vdata;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [LW-1:0]        cmd_layer;
  logic [1:0]           cmd_op;
  logic signed [HW-1:0] cmd_h;
  logic signed [VW-1:0] cmd_v;
  logic                 cmd_err;
  logic [N*HW-1:0]      hoffset;
  logic [N*VW-1:0]      voffset;
  logic                 frame_tick;
  logic                 busy;
  logic                 dbg_state;

  layer_scroll_seq #(
    .NLAYERS(N), .HWIDTH(HW), .VWIDTH(VW), .HSIZE(HS), .VSIZE(VS), .LWIDTH(LW)
  ) dut (
    .clk(clk), .rst(rst), .hdata(hdata), .vdata(vdata),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_layer(cmd_layer),
    .cmd_op(cmd_op), .cmd_h(cmd_h), .cmd_v(cmd_v), .cmd_err(cmd_err),
    .hoffset(hoffset), .voffset(voffset), .frame_tick(frame_tick),
    .busy(busy), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;
  int busy_cnt = 0;
  int tick_cnt = 0;

  // reference model: plain integers per layer
  int m_sp_h[N], m_sp_v[N], m_vel_h[N], m_vel_v[N], m_act_h[N], m_act_v[N];
  int m_pos;  // -1 idle, else next layer to commit
  bit m_tick, m_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int wrapm(input int x, input int m);
    return ((x % m) + m) % m;
  endfunction

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_sp_h[i] = 0; m_sp_v[i] = 0; m_vel_h[i] = 0; m_vel_v[i] = 0;
      m_act_h[i] = 0; m_act_v[i] = 0;
    end
    m_pos = -1; m_tick = 0; m_err = 0;
  endtask

  task automatic model_cmd();
    int h, v, l;
    bit ok;
    h = int'(cmd_h);
    v = int'(cmd_v);
    l = int'(cmd_layer);
    ok = 1;
    case (cmd_op)
      2'd0: begin
        ok = (l < N) && h >= 0 && h < HS && v >= 0 && v < VS;
        if (ok) begin m_sp_h[l] = h; m_sp_v[l] = v; end
      end
      2'd1: begin
        ok = (l < N) && iabs(h) <= HS - 1 && iabs(v) <= VS - 1;
        if (ok) begin m_vel_h[l] = h; m_vel_v[l] = v; end
      end
      2'd2: begin
        ok = (l < N) && iabs(h) <= HS - 1 && iabs(v) <= VS - 1;
        if (ok) begin
          m_sp_h[l] = wrapm(m_sp_h[l] + h, HS);
          m_sp_v[l] = wrapm(m_sp_v[l] + v, VS);
        end
      end
      default: begin
        for (int i = 0; i < N; i++) begin m_vel_h[i] = 0; m_vel_v[i] = 0; end
      end
    endcase
    m_err = !ok;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_clear();
      return;
    end
    m_tick = 0;
    m_err = 0;
    if (m_pos < 0) begin
      if (cmd_valid) model_cmd();
      if (hdata == 0 && vdata == VS) begin
        m_tick = 1;
        m_pos = 0;
      end
    end else begin
      m_sp_h[m_pos] = wrapm(m_sp_h[m_pos] + m_vel_h[m_pos], HS);
      m_sp_v[m_pos] = wrapm(m_sp_v[m_pos] + m_vel_v[m_pos], VS);
      m_act_h[m_pos] = m_sp_h[m_pos];
      m_act_v[m_pos] = m_sp_v[m_pos];
      m_pos++;
      if (m_pos == N) m_pos = -1;
    end
  endtask

  task automatic compare_all();
    logic [63:0] eh, ev;
    eh = '0;
    ev = '0;
    for (int i = 0; i < N; i++) begin
      eh[i*HW +: HW] = HW'(m_act_h[i]);
      ev[i*VW +: VW] = VW'(m_act_v[i]);
    end
    check("hoffset", 64'(hoffset), eh);
    check("voffset", 64'(voffset), ev);
    check("cmd_ready", 64'(cmd_ready), 64'(m_pos < 0));
    check("busy", 64'(busy), 64'(m_pos >= 0));
    check("frame_tick", 64'(frame_tick), 64'(m_tick));
    check("cmd_err", 64'(cmd_err), 64'(m_err));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    if (busy) busy_cnt++;
    if (frame_tick) tick_cnt++;
  endtask

  task automatic idle_cmd();
    cmd_valid = 0; cmd_layer = '0; cmd_op = 2'd0; cmd_h = '0; cmd_v = '0;
  endtask

  task automatic set_cmd(input logic [1:0] op, input int layer, input int h, input int v);
    cmd_valid = 1; cmd_op = op; cmd_layer = LW'(layer); cmd_h = HW'(h); cmd_v = VW'(v);
  endtask

  task automatic no_bnd();
    hdata = HW'($urandom_range(0, 799));
    vdata = VW'($urandom_range(0, 524));
    if (hdata == 0 && vdata == VW'(VS)) hdata = 1;
  endtask

  task automatic bnd();
    hdata = '0;
    vdata = VW'(VS);
  endtask

  task automatic do_cmd(input logic [1:0] op, input int layer, input int h, input int v);
    set_cmd(op, layer, h, v);
    no_bnd();
    step();
    idle_cmd();
  endtask

  task automatic run_frame();
    bnd();
    step();
    no_bnd();
    repeat (N + 2) step();
  endtask

  function automatic logic [HW-1:0] rand_h();
    case ($urandom_range(0, 3))
      0: return HW'($urandom_range(0, HS - 1));
      1: return HW'(int'($urandom_range(0, 2 * HS - 2)) - (HS - 1));
      2: return HW'($urandom_range(0, 4095));
      default: begin
        case ($urandom_range(0, 3))
          0: return HW'(HS - 1);
          1: return HW'(HS);
          2: return HW'(-(HS - 1));
          default: return HW'(-HS);
        endcase
      end
    endcase
  endfunction

  function automatic logic [VW-1:0] rand_v();
    case ($urandom_range(0, 3))
      0: return VW'($urandom_range(0, VS - 1));
      1: return VW'(int'($urandom_range(0, 2 * VS - 2)) - (VS - 1));
      2: return VW'($urandom_range(0, 4095));
      default: begin
        case ($urandom_range(0, 3))
          0: return VW'(VS - 1);
          1: return VW'(VS);
          2: return VW'(-(VS - 1));
          default: return VW'(-VS);
        endcase
      end
    endcase
  endfunction

  initial begin
    int stalls, acc;
    model_clear();
    rst = 1;
    idle_cmd();
    no_bnd();

    // reset and first commit
    repeat (3) step();
    rst = 0;
    step();
    check("reset_ready", 64'(cmd_ready), 64'd1);
    check("reset_hoff", 64'(hoffset), 64'd0);
    busy_cnt = 0;
    tick_cnt = 0;
    bnd();
    step();
    no_bnd();
    repeat (7) step();
    check("first_busy_cycles", 64'(busy_cnt), 64'd4);
    check("first_tick_cycles", 64'(tick_cnt), 64'd1);
    check("first_hoff", 64'(hoffset), 64'd0);

    // basic scroll on layer 1
    do_cmd(2'd1, 1, 3, -2);
    for (int k = 1; k <= 3; k++) begin
      bnd();
      step();
      no_bnd();
      step();
      check("scroll_hold_h", 64'(hoffset[1*HW +: HW]), 64'(3 * (k - 1)));
      step();
      check("scroll_h", 64'(hoffset[1*HW +: HW]), 64'(3 * k));
      check("scroll_v", 64'(voffset[1*VW +: VW]), 64'(VS - 2 * k));
      check("scroll_l2_h", 64'(hoffset[2*HW +: HW]), 64'd0);
      repeat (3) step();
    end

    // wrap on layer 0
    do_cmd(2'd0, 0, 638, 1);
    do_cmd(2'd1, 0, 5, -4);
    run_frame();
    check("wrap_h", 64'(hoffset[0 +: HW]), 64'd3);
    check("wrap_v", 64'(voffset[0 +: VW]), 64'd477);

    // rejected commands leave state alone
    do_cmd(2'd0, 2, 640, 0);
    check("err_setpos", 64'(cmd_err), 64'd1);
    do_cmd(2'd1, 2, 0, 480);
    check("err_setvel", 64'(cmd_err), 64'd1);
    do_cmd(2'd2, 2, -640, 0);
    check("err_addpos", 64'(cmd_err), 64'd1);
    step();
    check("err_oneshot", 64'(cmd_err), 64'd0);
    run_frame();
    check("err_l2_h", 64'(hoffset[2*HW +: HW]), 64'd0);
    check("err_l2_v", 64'(voffset[2*VW +: VW]), 64'd0);

    // command in the boundary cycle is seen by that commit
    bnd();
    set_cmd(2'd1, 3, 1, 1);
    step();
    idle_cmd();
    no_bnd();
    repeat (N + 2) step();
    check("race_h", 64'(hoffset[3*HW +: HW]), 64'd1);
    check("race_v", 64'(voffset[3*VW +: VW]), 64'd1);

    // command held through APPLY is stalled then taken once
    bnd();
    step();
    no_bnd();
    set_cmd(2'd2, 3, 10, 0);
    stalls = 0;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      if (cmd_ready) begin
        acc++;
        step();
        idle_cmd();
        break;
      end
      stalls++;
      step();
    end
    check("stall_cycles", 64'(stalls), 64'd4);
    check("stall_accepts", 64'(acc), 64'd1);
    repeat (2) step();
    check("cmd_no_active", 64'(hoffset[3*HW +: HW]), 64'd2);
    run_frame();
    check("stall_applied", 64'(hoffset[3*HW +: HW]), 64'd13);

    // reset during APPLY
    bnd();
    step();
    no_bnd();
    step();
    rst = 1;
    step();
    check("rst_mid_hoff", 64'(hoffset), 64'd0);
    check("rst_mid_voff", 64'(voffset), 64'd0);
    check("rst_mid_ready", 64'(cmd_ready), 64'd1);
    check("rst_mid_state", 64'(dbg_state), 64'd0);
    rst = 0;
    step();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 9) < 6) begin
        cmd_valid = 1;
        cmd_op = 2'($urandom_range(0, 3));
        cmd_layer = LW'($urandom_range(0, N - 1));
        cmd_h = rand_h();
        cmd_v = rand_v();
      end else begin
        idle_cmd();
      end
      if ($urandom_range(0, 11) == 0) bnd();
      else no_bnd();
      step();
    end
    rst = 0;
    idle_cmd();
    no_bnd();
    repeat (N + 2) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
